frame_seq_gen: RTL
==================

Name: frame_seq_gen

Overview:
Transmitter side of the frame-sequencing interface: generates frameStart / mode / frameEnd / burstDone toward the frame-progress FSM and checks its progress acknowledge. A host issues one transaction per request (single frame or burst of N frames, each L cycles long). The block sequences the strobes with fixed spacing, then waits for progress to confirm completion, with a timeout.

Parameters:
FRAME_LEN_W, 8, width of frame length field (data cycles per frame)
BURST_CNT_W, 4, width of burst frame-count field
GAP_CYCLES, 2, idle cycles between frameEnd and the next frameStart inside a burst (0 allowed)
ACK_TIMEOUT, 16, max cycles in ACK_WAIT before error

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
req  in  1  transaction request, accepted when req && req_ready
req_mode  in  1  0 = single frame, 1 = burst
req_frame_len  in  FRAME_LEN_W  data cycles per frame (0 treated as 1)
req_burst_cnt  in  BURST_CNT_W  frames in burst (0 treated as 1; ignored when req_mode=0)
req_ready  out  1  high only in IDLE
frameStart  out  1  one-cycle pulse at start of each frame
mode  out  1  latched req_mode, valid from first frameStart to exit of ACK_WAIT, else 0
frameEnd  out  1  one-cycle pulse on last data cycle of each frame
burstDone  out  1  one-cycle pulse, burst mode only
progress  in  1  acknowledge level from consumer
busy  out  1  high in every state except IDLE
ack_err  out  1  one-cycle pulse on acknowledge timeout

Behaviour:
- Clock clk; reset asynchronous, active-low. Reset (including mid-transaction): state IDLE, all counters 0, frameStart/frameEnd/burstDone/mode/busy/ack_err = 0, req_ready = 1. All outputs registered.
- States: IDLE, START, FRAME, GAP, BDONE, ACK_WAIT.
- IDLE: on req && req_ready at edge T, latch mode, L = max(len,1), N = mode ? max(cnt,1) : 1. Go to START. req while busy is ignored and not queued.
- START: frameStart = 1 in cycle T+1; mode driven from here. Clear seen_low flag. Go to FRAME.
- FRAME: L cycles, T+2..T+1+L. frameEnd = 1 on the L-th cycle. frameStart and frameEnd are never high in the same cycle.
  - Frames remaining > 0 after this one: go to GAP, or START if GAP_CYCLES = 0.
  - Else mode 0: go to ACK_WAIT.
  - Else mode 1: go to BDONE.
- GAP: GAP_CYCLES cycles with all strobes low, then START. Every burst frame emits its own frameStart.
- BDONE: burstDone = 1 for exactly one cycle (the cycle after the final frameEnd), then ACK_WAIT.
- Acknowledge: seen_low sets when progress = 0 is sampled on any cycle after the first frameStart of the transaction. This rejects a stale progress = 1 left from the previous transaction.
- ACK_WAIT: completes when seen_low && progress = 1, then goes to IDLE (mode -> 0). The timeout counter starts at 0 on entry. If it reaches ACK_TIMEOUT without completion, ack_err pulses one cycle and the state returns to IDLE.
- Counters saturate-free: frame counter is FRAME_LEN_W bits, burst counter is BURST_CNT_W bits, timeout counter is $clog2(ACK_TIMEOUT+1) bits. No wrap occurs given the clamps above.
- Max-length values (all-ones len/cnt) are legal and run fully.

Optional Feature:
FRAME_SEQ_GEN_ABORT_EN:
- Defined: adds input abort (1 bit). When abort is sampled high in START, FRAME or GAP, the next cycle emits a one-cycle terminator: frameEnd if mode 0, burstDone if mode 1. The block then goes to IDLE without ACK_WAIT and without ack_err.
- abort is ignored in IDLE, BDONE and ACK_WAIT.
- Not defined: no abort port; transactions always run to completion or timeout.

Test Plan:
- Single frame: req, mode 0, len 3 at T -> frameStart at T+1, frameEnd at T+4, burstDone never. Drive progress low at T+2 and high at T+6 -> busy falls, req_ready = 1 at T+7.
- Burst: mode 1, len 2, cnt 3, GAP 2 -> frameStart at T+1, T+6, T+11; frameEnd at T+3, T+8, T+13; burstDone at T+14 only; mode = 1 throughout.
- Stale ack: progress held 1 for the whole transaction -> no completion; ack_err pulses exactly ACK_TIMEOUT cycles after ACK_WAIT entry, then IDLE.
- Clamps: len 0, cnt 0, mode 1 -> one frame of 1 data cycle, frameStart at T+1, frameEnd at T+2, burstDone at T+3. req held high during busy -> exactly one transaction.
- Reset mid-burst: assert reset_n low during a FRAME of frame 2 -> all outputs 0 immediately; after release, req_ready = 1 and a new request runs cleanly.
- Abort (macro defined): abort in FRAME cycle 2 of len 5, mode 0 -> frameEnd next cycle, IDLE after, no ack_err.

Source files
------------

// File: rtl/frame_seq_gen_if.sv
// frame_seq_gen_if: host request, frame strobes and progress acknowledge for frame_seq_gen.
// The abort input exists only when FRAME_SEQ_GEN_ABORT_EN is defined.
interface frame_seq_gen_if #(
  parameter int FRAME_LEN_W = 8,
  parameter int BURST_CNT_W = 4
);
  logic req, req_mode, req_ready;
  logic [FRAME_LEN_W-1:0] req_frame_len;
  logic [BURST_CNT_W-1:0] req_burst_cnt;
  logic frameStart, mode, frameEnd, burstDone, progress, busy, ack_err;
`ifdef FRAME_SEQ_GEN_ABORT_EN
  logic abort;
  modport master (
    input  req, req_mode, req_frame_len, req_burst_cnt, progress, abort,
    output req_ready, frameStart, mode, frameEnd, burstDone, busy, ack_err
  );
  modport slave (
    output req, req_mode, req_frame_len, req_burst_cnt, progress, abort,
    input  req_ready, frameStart, mode, frameEnd, burstDone, busy, ack_err
  );
`else
  modport master (
    input  req, req_mode, req_frame_len, req_burst_cnt, progress,
    output req_ready, frameStart, mode, frameEnd, burstDone, busy, ack_err
  );
  modport slave (
    output req, req_mode, req_frame_len, req_burst_cnt, progress,
    input  req_ready, frameStart, mode, frameEnd, burstDone, busy, ack_err
  );
`endif
endinterface

// File: rtl/frame_seq_gen.sv
// frame_seq_gen: sequences frameStart/frameEnd/burstDone for single or burst transactions and
// waits for a fresh progress acknowledge with timeout; FRAME_SEQ_GEN_ABORT_EN adds an abort input.
module frame_seq_gen #(
  parameter int FRAME_LEN_W = 8,
  parameter int BURST_CNT_W = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input logic             clk,
  input logic             reset_n,
  frame_seq_gen_if.master bus
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  typedef enum logic [2:0] {IDLE, START, FRAME, GAP, BDONE, ACK_WAIT} state_t;
  state_t state_q;
  logic mode_q, first_q, seen_low_q, abt_q;
  logic fs_q, fe_q, bd_q, ready_q, busy_q, err_q;
  logic [FRAME_LEN_W-1:0] len_q, fcnt_q;
  logic [BURST_CNT_W-1:0] rem_q;
  logic [GW-1:0] gcnt_q;
  logic [TW-1:0] tcnt_q;
  logic abort;
`ifdef FRAME_SEQ_GEN_ABORT_EN
  assign abort = bus.abort && (state_q inside {START, FRAME, GAP});
`else
  assign abort = 1'b0;
`endif
  // fcnt_q holds data cycles still to come in the current frame, rem_q frames still to come in the burst
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      first_q    <= 1'b0;
      seen_low_q <= 1'b0;
      abt_q      <= 1'b0;
      fs_q       <= 1'b0;
      fe_q       <= 1'b0;
      bd_q       <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      len_q      <= '0;
      fcnt_q     <= '0;
      rem_q      <= '0;
      gcnt_q     <= '0;
      tcnt_q     <= '0;
    end else begin
      fs_q  <= 1'b0;
      fe_q  <= 1'b0;
      bd_q  <= 1'b0;
      err_q <= 1'b0;
      // a low progress only counts once the first frameStart is behind us, so a stale high is rejected
      if (state_q != IDLE && !(state_q == START && first_q))
        seen_low_q <= seen_low_q | ~bus.progress;
      if (abort) begin
        state_q <= BDONE;
        fe_q    <= ~mode_q;
        bd_q    <= mode_q;
        abt_q   <= 1'b1;
      end else
        case (state_q)
          IDLE:
            if (bus.req) begin
              state_q    <= START;
              fs_q       <= 1'b1;
              mode_q     <= bus.req_mode;
              first_q    <= 1'b1;
              seen_low_q <= 1'b0;
              len_q      <= bus.req_frame_len == '0 ? FRAME_LEN_W'(1) : bus.req_frame_len;
              rem_q      <= bus.req_mode && bus.req_burst_cnt != '0 ? bus.req_burst_cnt - 1'b1 : '0;
              ready_q    <= 1'b0;
              busy_q     <= 1'b1;
            end
          START: begin
            state_q <= FRAME;
            first_q <= 1'b0;
            fcnt_q  <= len_q - 1'b1;
            fe_q    <= len_q == FRAME_LEN_W'(1);
          end
          FRAME:
            if (fcnt_q != '0) begin
              fcnt_q <= fcnt_q - 1'b1;
              fe_q   <= fcnt_q == FRAME_LEN_W'(1);
            end else if (rem_q != '0) begin
              rem_q <= rem_q - 1'b1;
              if (GAP_CYCLES == 0) begin
                state_q <= START;
                fs_q    <= 1'b1;
              end else begin
                state_q <= GAP;
                gcnt_q  <= GW'(GAP_CYCLES - 1);
              end
            end else if (mode_q) begin
              state_q <= BDONE;
              bd_q    <= 1'b1;
            end else begin
              state_q <= ACK_WAIT;
              tcnt_q  <= '0;
            end
          GAP:
            if (gcnt_q != '0) gcnt_q <= gcnt_q - 1'b1;
            else begin
              state_q <= START;
              fs_q    <= 1'b1;
            end
          BDONE:
            if (abt_q) begin
              state_q <= IDLE;
              mode_q  <= 1'b0;
              abt_q   <= 1'b0;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ACK_WAIT;
              tcnt_q  <= '0;
            end
          ACK_WAIT:
            if ((seen_low_q && bus.progress) || tcnt_q == TW'(ACK_TIMEOUT - 1)) begin
              state_q <= IDLE;
              mode_q  <= 1'b0;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              err_q   <= ~(seen_low_q && bus.progress);
            end else tcnt_q <= tcnt_q + 1'b1;
          default: state_q <= IDLE;
        endcase
    end
  assign bus.req_ready  = ready_q;
  assign bus.busy       = busy_q;
  assign bus.frameStart = fs_q;
  assign bus.frameEnd   = fe_q;
  assign bus.burstDone  = bd_q;
  assign bus.mode       = mode_q;
  assign bus.ack_err    = err_q;
endmodule
